// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdu_pkg                                                      |
// | Description : Shared encodings and constants for the multiply/divide unit. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int MDU_ITERATIONS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_div_unit_if                                             |
// | Description : Request/result bundle between the pipeline and the MDU.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mult_div_unit_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, op, src_a, src_b, mthi, mtlo, mt_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, src_a, src_b, mthi, mtlo, mt_data,
        output hi, lo, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/mdu_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdu_seq_core                                                 |
// | Description : Radix-2 iterative engine, shift-add or restoring divide.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mdu_seq_core
    import mdu_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_load,
    input  wire logic        i_step,
    input  wire logic        i_is_div,
    input  wire logic [31:0] i_mag_a,
    input  wire logic [31:0] i_mag_b,
    output logic             o_last,
    output logic [31:0]      o_hi,
    output logic [31:0]      o_lo
);

    localparam logic [4:0] c_last_count = 5'(MDU_ITERATIONS - 1);

    logic [63:0] r_acc;
    logic [31:0] r_rem;
    logic [31:0] r_shift;
    logic [31:0] r_b;
    logic [4:0]  r_count;

    logic [31:0] w_addend;
    logic [32:0] w_sum;
    logic [32:0] w_part_rem;
    logic        w_ge;
    logic [31:0] w_diff;

    always_comb begin
        w_addend   = r_shift[0] ? r_b : 32'd0;
        w_sum      = {1'b0, r_acc[63:32]} + {1'b0, w_addend};
        w_part_rem = {r_rem, r_shift[31]};
        w_ge       = (w_part_rem >= {1'b0, r_b});
        // Only taken when w_ge holds, so the true difference always fits 32 bits.
        w_diff     = w_part_rem[31:0] - r_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_rem   <= '0;
            r_shift <= '0;
            r_b     <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_rem   <= '0;
            r_shift <= i_mag_a;
            r_b     <= i_mag_b;
            r_count <= '0;
        end else if (i_step) begin
            r_count <= r_count + 5'd1;
            if (i_is_div) begin
                r_rem        <= w_ge ? w_diff : w_part_rem[31:0];
                r_acc[31:0]  <= {r_acc[30:0], w_ge};
                r_shift      <= {r_shift[30:0], 1'b0};
            end else begin
                r_acc   <= {w_sum, r_acc[31:1]};
                r_shift <= {1'b0, r_shift[31:1]};
            end
        end
    end

    assign o_last = (r_count == c_last_count);
    assign o_hi   = i_is_div ? r_rem : r_acc[63:32];
    assign o_lo   = r_acc[31:0];

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_div_unit                                                |
// | Description : HI/LO owner; sequences MULT/MULTU/DIV/DIVU in 34 cycles.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mult_div_unit
    import mdu_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    mult_div_unit_if.slave   bus
);

    mdu_state_t  r_state;
    mdu_state_t  w_next_state;
    logic        w_load;
    logic        w_step;
    logic        w_fix;

    logic [1:0]  r_op;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_div_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_signed;
    logic        w_is_div;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_last;
    logic [31:0] w_core_hi;
    logic [31:0] w_core_lo;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fixed;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_signed = op_is_signed(bus.op);
    assign w_is_div = op_is_div(r_op);
    assign w_mag_a  = (w_signed && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    assign w_mag_b  = (w_signed && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;

    mdu_seq_core u_core (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_is_div (w_is_div),
        .i_mag_a  (w_mag_a),
        .i_mag_b  (w_mag_b),
        .o_last   (w_last),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = ST_FIX;
                end
            end
            ST_FIX: begin
                w_fix        = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= MDU_MULT;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_load) begin
            r_op       <= bus.op;
            r_neg_res  <= w_signed && (bus.src_a[31] ^ bus.src_b[31]);
            r_neg_rem  <= w_signed && bus.src_a[31];
            r_div_zero <= (bus.src_b == 32'd0);
        end
    end

    // Divide by zero: the remainder path already reproduces the dividend,
    // only the quotient needs forcing to all ones regardless of sign.
    always_comb begin
        w_prod       = {w_core_hi, w_core_lo};
        w_prod_fixed = r_neg_res ? (64'd0 - w_prod) : w_prod;
        w_quot       = r_div_zero ? 32'hFFFF_FFFF
                     : (r_neg_res ? (32'd0 - w_core_lo) : w_core_lo);
        w_rem        = r_neg_rem ? (32'd0 - w_core_hi) : w_core_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix) begin
            if (w_is_div) begin
                r_hi <= w_rem;
                r_lo <= w_quot;
            end else begin
                r_hi <= w_prod_fixed[63:32];
                r_lo <= w_prod_fixed[31:0];
            end
        end else if (r_state == ST_IDLE) begin
            if (bus.mthi) begin
                r_hi <= bus.mt_data;
            end
            if (bus.mtlo) begin
                r_lo <= bus.mt_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix;
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = (r_state != ST_IDLE);
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mult_div_unit                                             |
// | Description : Directed scoreboard bench for the multiply/divide unit.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_div_unit_if bus();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks     = 0;
    int          errors     = 0;
    int          done_count = 0;
    logic [63:0] exp_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse consumes one expected {HI,LO}.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            logic [63:0] exp_v;
            done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 hi=%h lo=%h", bus.hi, bus.lo);
            end else begin
                exp_v = exp_q.pop_front();
                check32("result_hi", bus.hi, exp_v[63:32]);
                check32("result_lo", bus.lo, exp_v[31:0]);
            end
        end
    end

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_v, input bit disturb);
        int n;
        int busy_n;
        int done_before;
        exp_q.push_back(exp_v);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        tick;
        bus.start   = 1'b0;
        bus.src_a   = ~a;
        bus.src_b   = ~b;
        n           = 0;
        busy_n      = 0;
        done_before = done_count;
        while (!bus.done && n < 60) begin
            if (bus.busy) busy_n++;
            if (disturb && n == 5) begin
                bus.start   = 1'b1;
                bus.op      = op ^ 2'b10;
                bus.src_a   = 32'h0000_1111;
                bus.src_b   = 32'h0000_0003;
                bus.mthi    = 1'b1;
                bus.mt_data = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
            end
            tick;
            n++;
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        check32({name, "_latency"}, 32'(n), 32'd33);
        check32({name, "_busy_cycles"}, 32'(busy_n), 32'd33);
        check32({name, "_busy_low_at_done"}, 32'(bus.busy), 32'd0);
        tick;
        check32({name, "_done_one_shot"}, 32'(bus.done), 32'd0);
        check32({name, "_idle_after"}, 32'(bus.busy), 32'd0);
        check32({name, "_done_count"}, 32'(done_count), 32'(done_before + 1));
    endtask

    initial begin
        int done_before;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = MDU_MULT;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.mt_data = '0;
        repeat (2) tick;
        check32("reset_hi", bus.hi, 32'd0);
        check32("reset_lo", bus.lo, 32'd0);
        check32("reset_busy", 32'(bus.busy), 32'd0);
        check32("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        tick;

        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("mult_neg",  MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        run_op("multu_neg", MDU_MULTU, 32'hFFFF_FFFD, 32'h0000_0005, 64'h0000_0004_FFFF_FFF1, 1'b0);
        run_op("mult_min",  MDU_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        run_op("div_neg",   MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("divu",      MDU_DIVU,  32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003, 1'b0);
        run_op("div_negb",  MDU_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, 1'b0);
        run_op("div_zero",  MDU_DIV,   32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF, 1'b0);
        run_op("div_zero_neg", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF, 1'b0);
        run_op("divu_zero", MDU_DIVU,  32'h8000_0001, 32'h0000_0000, 64'h8000_0001_FFFF_FFFF, 1'b0);
        run_op("div_ovf",   MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);

        bus.mtlo    = 1'b1;
        bus.mt_data = 32'hA5A5_A5A5;
        tick;
        bus.mtlo = 1'b0;
        check32("mtlo_lo", bus.lo, 32'hA5A5_A5A5);
        check32("mtlo_hi_kept", bus.hi, 32'h0000_0000);
        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        bus.mt_data = 32'h5A5A_0F0F;
        tick;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check32("mtboth_hi", bus.hi, 32'h5A5A_0F0F);
        check32("mtboth_lo", bus.lo, 32'h5A5A_0F0F);

        run_op("divu_disturbed", MDU_DIVU, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 1'b1);

        bus.start = 1'b1;
        bus.op    = MDU_DIV;
        bus.src_a = 32'h0000_03E8;
        bus.src_b = 32'h0000_0003;
        tick;
        bus.start = 1'b0;
        repeat (10) tick;
        done_before = done_count;
        reset = 1'b1;
        tick;
        check32("abort_busy", 32'(bus.busy), 32'd0);
        check32("abort_done", 32'(bus.done), 32'd0);
        check32("abort_hi", bus.hi, 32'd0);
        check32("abort_lo", bus.lo, 32'd0);
        reset = 1'b0;
        repeat (40) tick;
        check32("abort_no_done", 32'(done_count), 32'(done_before));
        check32("abort_idle", 32'(bus.busy), 32'd0);

        run_op("multu_after_reset", MDU_MULTU, 32'h0000_0006, 32'h0000_0007, 64'h0000_0000_0000_002A, 1'b0);

        repeat (3) tick;
        check32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the pipelined MIPS core. It sits beside the EX stage and owns the HI/LO registers. It executes MULT/MULTU/DIV/DIVU over a fixed number of cycles and supplies HI/LO to the writeback path, so MFHI/MFLO results reach the register file through the normal WB write port. Its `busy` output feeds the hazard unit, which stalls the pipeline.

## Interface
- Parameters: none; the datapath is fixed at 32 bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin the operation given by `op`; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a`  in  32  rs operand (multiplicand or dividend).
- `src_b`  in  32  rt operand (multiplier or divisor).
- `mthi`  in  1  write `mt_data` to HI.
- `mtlo`  in  1  write `mt_data` to LO.
- `mt_data`  in  32  rs value for MTHI/MTLO.
- `hi`  out  32  HI register; reset value 0.
- `lo`  out  32  LO register; reset value 0.
- `busy`  out  1  operation in progress; reset value 0.
- `done`  out  1  one-cycle pulse when HI/LO take a new result; reset value 0.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: performs 32 iterations under a 5-bit counter.
  - FIX: applies sign correction and writes HI/LO.
- IDLE→RUN on `start`:
  - Latch `op`.
  - For signed ops, latch the operand magnitudes, the result sign, and the dividend sign.
  - Clear the 64-bit accumulator and the counter.
- Multiply in RUN: radix-2 shift-add on magnitudes, one bit per cycle, 64-bit accumulator.
- Divide in RUN: radix-2 restoring shift-subtract, one quotient bit per cycle, 33-bit partial remainder.
- RUN→FIX when the counter reaches 31. FIX→IDLE unconditionally.
- FIX sign rules:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - All arithmetic wraps modulo 2^32 (or 2^64 for products).
- FIX write: HI = product[63:32] or remainder; LO = product[31:0] or quotient.
- Divide by zero (any signedness): completes with normal latency, HI = `src_a` as latched, LO = 32'hFFFFFFFF. No exception.
- 0x80000000 DIV 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wrapped).
- `start` while `busy`: ignored. The hazard unit guarantees it never happens; the bench checks that it is ignored.
- `mthi`/`mtlo` in IDLE: the named register updates at the edge.
  - Both may be asserted together; both registers are written.
  - If `start` is asserted in the same cycle, the MT write still happens and is later overwritten in FIX.
- `mthi`/`mtlo` while `busy`: ignored.
- `reset` at any time, including mid-operation: state returns to IDLE, the counter clears, HI = LO = 0, `busy` = `done` = 0, and the in-flight operation is discarded.

## Timing
- `start` is sampled at edge E0.
- `busy` is high from the cycle after E0 through E33; it falls at E33, the same edge at which HI/LO update.
- Edges E1–E32 are the iterations; E33 is FIX.
- `done` is registered: high for exactly the one cycle after E33, while the new HI/LO are already visible.
- Latency from `start` to a readable result is 34 cycles. A new `start` may be presented in the cycle where `done` is high.
- MT writes are visible on `hi`/`lo` in the cycle after the edge that samples them.
- `hi`/`lo` are pure register outputs; there is no combinational path from any input.

## Structure
- Shared package `mdu_pkg` holds:
  - The op encodings (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`).
  - The state encoding (IDLE/RUN/FIX).
  - The iteration count constant 32.
- One sub-module, `mdu_seq_core`, holds the shared iterative engine: accumulator/remainder register, counter, and the shift-add versus shift-subtract step selected by a mul/div flag.
- The top level holds:
  - Operand sign preparation.
  - The FIX sign correction.
  - The HI/LO registers and MT writes.
  - The state machine and `busy`/`done`.

## Test plan
1. MULTU with 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. `busy` is high for 33 cycles and `done` pulses once, 34 cycles after `start`.
2. MULT with −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. MULTU with the same operands → HI = 0x00000004, LO = 0xFFFFFFF1.
3. DIV with −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU with 7 / 2 → LO = 3, HI = 1.
4. DIV with 0x12345678 / 0 → HI = 0x12345678, LO = 0xFFFFFFFF. DIV with 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
5. In IDLE, `mtlo` with 0xA5A5A5A5 → `lo` = 0xA5A5A5A5 the next cycle. During `busy`: a `start` with other operands and an `mthi` are both ignored, and the original result lands unchanged.
6. Assert `reset` at iteration 10 of a DIV → next cycle `busy` = 0, `done` = 0, HI = LO = 0, with no later `done`. A following MULTU 6 × 7 → LO = 42, HI = 0, with normal latency.
